// File: rtl/spi_bank_pkg.sv
// Shared defaults and types for the SPI/hardware register-bank write path.
package spi_bank_pkg;

  localparam int NUM_HW_DEF = 2;
  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 8;

  typedef logic [ADDR_W_DEF-1:0] addr_t;
  typedef logic [DATA_W_DEF-1:0] data_t;

  // Pointer width able to index n requesters (at least one bit).
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: searches req starting at ptr and
// returns a one-hot grant for the first active requester found.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  int   idx;
  logic found;

  // Circular scan from ptr; first requester hit wins.
  always_comb begin
    // NOTE: every variable gets a default here so no latch is inferred.
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Register-bank write arbiter: SPI writes take priority over hardware
// requesters, which share the remaining slots round-robin. A one-deep hold
// register keeps an SPI write that arrives while the block is disabled.
module reg_bank_arbiter
  import spi_bank_pkg::*;
#(
  parameter int NUM_HW = NUM_HW_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                           clk,
  input  logic                           rstb,
  input  logic                           ena,
  input  logic                           spi_wr_vld,
  input  logic [ADDR_W-1:0]              spi_wr_addr,
  input  logic [DATA_W-1:0]              spi_wr_data,
  input  logic [NUM_HW-1:0]              hw_req,
  input  logic [NUM_HW-1:0][ADDR_W-1:0]  hw_addr,
  input  logic [NUM_HW-1:0][DATA_W-1:0]  hw_data,
  output logic [NUM_HW-1:0]              hw_gnt,
  output logic                           wr_en,
  output logic [ADDR_W-1:0]              wr_addr,
  output logic [DATA_W-1:0]              wr_data,
  output logic                           spi_ovf,
  input  logic                           ovf_clr
);

  localparam int PTR_W = ptr_width(NUM_HW);

  logic              hold_vld;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;
  logic [PTR_W-1:0]  rr_ptr;

  logic              spi_pend;
  logic              spi_issue;
  logic              hw_sel;
  logic              hw_xfer;
  logic [NUM_HW-1:0] rr_gnt;
  logic [PTR_W-1:0]  gnt_idx;
  logic [PTR_W-1:0]  ptr_next;
  logic [ADDR_W-1:0] spi_addr_src;
  logic [DATA_W-1:0] spi_data_src;
  logic [ADDR_W-1:0] hw_addr_sel;
  logic [DATA_W-1:0] hw_data_sel;

  assign spi_pend  = spi_wr_vld | hold_vld;
  assign spi_issue = ena & spi_pend;
  // rstb is in the gate so grants drop asynchronously with reset.
  assign hw_sel    = rstb & ena & ~spi_pend;

  rr_arbiter #(
    .N     (NUM_HW),
    .PTR_W (PTR_W)
  ) u_rr (
    .req (hw_req),
    .ptr (rr_ptr),
    .gnt (rr_gnt)
  );

  assign hw_gnt  = hw_sel ? rr_gnt : '0;
  assign hw_xfer = |(hw_gnt & hw_req);

  // Older held write goes out before a newly arriving strobe.
  assign spi_addr_src = hold_vld ? hold_addr : spi_wr_addr;
  assign spi_data_src = hold_vld ? hold_data : spi_wr_data;

  // Decode the one-hot grant into an index for data muxing and pointer update.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_HW; i++) begin
      if (rr_gnt[i]) gnt_idx = PTR_W'(i);
    end
  end

  assign hw_addr_sel = hw_addr[gnt_idx];
  assign hw_data_sel = hw_data[gnt_idx];
  assign ptr_next    = (int'(gnt_idx) == NUM_HW - 1) ? '0 : gnt_idx + 1'b1;

  // Registered bank write port; address/data keep their last value when idle.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      wr_en <= spi_issue | hw_xfer;
      if (spi_issue) begin
        wr_addr <= spi_addr_src;
        wr_data <= spi_data_src;
      end else if (hw_xfer) begin
        wr_addr <= hw_addr_sel;
        wr_data <= hw_data_sel;
      end
    end
  end

  // One-deep SPI hold: captures strobes that cannot issue this cycle.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      // NOTE: hold contents are reset too, so a discarded write leaves no trace.
      hold_vld  <= 1'b0;
      hold_addr <= '0;
      hold_data <= '0;
    end else if (spi_wr_vld && (!ena || hold_vld)) begin
      hold_vld  <= 1'b1;
      hold_addr <= spi_wr_addr;
      hold_data <= spi_wr_data;
    end else if (ena && hold_vld) begin
      hold_vld <= 1'b0;
    end
  end

  // Sticky overflow: a held write was overwritten while disabled; set beats clear.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      spi_ovf <= 1'b0;
    end else if (spi_wr_vld && !ena && hold_vld) begin
      spi_ovf <= 1'b1;
    end else if (ovf_clr) begin
      spi_ovf <= 1'b0;
    end
  end

  // Round-robin pointer moves past the winner only on an actual hw transfer.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rr_ptr <= '0;
    end else if (hw_xfer) begin
      rr_ptr <= ptr_next;
    end
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench for reg_bank_arbiter: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_reg_bank_arbiter;
  import spi_bank_pkg::*;

  localparam int N = NUM_HW_DEF;

  typedef struct packed {
    addr_t a;
    data_t d;
  } spi_wr_t;

  logic               clk = 1'b0;
  logic               rstb = 1'b0;
  logic               ena = 1'b0;
  logic               spi_wr_vld = 1'b0;
  addr_t              spi_wr_addr = '0;
  data_t              spi_wr_data = '0;
  logic [N-1:0]       hw_req = '0;
  logic [N-1:0][ADDR_W_DEF-1:0] hw_addr = '0;
  logic [N-1:0][DATA_W_DEF-1:0] hw_data = '0;
  logic [N-1:0]       hw_gnt;
  logic               wr_en;
  addr_t              wr_addr;
  data_t              wr_data;
  logic               spi_ovf;
  logic               ovf_clr = 1'b0;

  reg_bank_arbiter dut (
    .clk         (clk),
    .rstb        (rstb),
    .ena         (ena),
    .spi_wr_vld  (spi_wr_vld),
    .spi_wr_addr (spi_wr_addr),
    .spi_wr_data (spi_wr_data),
    .hw_req      (hw_req),
    .hw_addr     (hw_addr),
    .hw_data     (hw_data),
    .hw_gnt      (hw_gnt),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .spi_ovf     (spi_ovf),
    .ovf_clr     (ovf_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: pending SPI writes in order, last hw winner, outputs.
  spi_wr_t hold_q[$];
  int      last_win;
  bit      m_ovf;
  bit      m_wr_en;
  addr_t   m_addr;
  data_t   m_data;

  task automatic model_reset();
    hold_q.delete();
    last_win = N - 1;
    m_ovf    = 1'b0;
    m_wr_en  = 1'b0;
    m_addr   = '0;
    m_data   = '0;
  endtask

  task automatic idle();
    spi_wr_vld = 1'b0;
    ovf_clr    = 1'b0;
  endtask

  // One clock: check DUT against model, advance model, move past the edge.
  task automatic step(output int g);
    logic [N-1:0] eg;
    bit      pend, had_hold, nxt_en, ovf_set;
    spi_wr_t nw;
    int      idx;
    #3;
    g    = -1;
    eg   = '0;
    pend = spi_wr_vld || (hold_q.size() > 0);
    if (ena && !pend) begin
      for (int k = 1; k <= N; k++) begin
        idx = (last_win + k) % N;
        if (g < 0 && hw_req[idx]) g = idx;
      end
    end
    if (g >= 0) eg[g] = 1'b1;
    check("hw_gnt", 32'(hw_gnt), 32'(eg));
    check("wr_en", 32'(wr_en), 32'(m_wr_en));
    check("wr_addr", 32'(wr_addr), 32'(m_addr));
    check("wr_data", 32'(wr_data), 32'(m_data));
    check("spi_ovf", 32'(spi_ovf), 32'(m_ovf));

    nxt_en   = 1'b0;
    ovf_set  = 1'b0;
    nw       = '0;
    had_hold = hold_q.size() > 0;
    if (ena && pend) begin
      nxt_en = 1'b1;
      if (had_hold) begin
        nw = hold_q.pop_front();
        if (spi_wr_vld) hold_q.push_back({spi_wr_addr, spi_wr_data});
      end else begin
        nw = {spi_wr_addr, spi_wr_data};
      end
    end else if (g >= 0) begin
      nxt_en   = 1'b1;
      nw       = {hw_addr[g], hw_data[g]};
      last_win = g;
    end
    if (!ena && spi_wr_vld) begin
      if (had_hold) begin
        ovf_set = 1'b1;
        hold_q.delete();
      end
      hold_q.push_back({spi_wr_addr, spi_wr_data});
    end
    if (ovf_set) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    m_wr_en = nxt_en;
    if (nxt_en) begin
      m_addr = nw.a;
      m_data = nw.d;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic spi(input bit en, input addr_t a, input data_t d);
    ena         = en;
    spi_wr_vld  = 1'b1;
    spi_wr_addr = a;
    spi_wr_data = d;
  endtask

  int g;

  initial begin
    model_reset();
    #1;
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_hw_gnt", 32'(hw_gnt), 0);
    check("rst_ovf", 32'(spi_ovf), 0);
    repeat (2) @(posedge clk);
    #1;
    rstb = 1'b1;
    step(g);

    // SPI write while enabled.
    spi(1'b1, 3'd5, 8'hA5);
    step(g);
    idle();
    check("spi_wr_en", 32'(wr_en), 1);
    check("spi_addr", 32'(wr_addr), 5);
    check("spi_data", 32'(wr_data), 32'hA5);
    step(g);

    // Two hw requesters held: hw0 then hw1.
    hw_addr[0] = 3'd6; hw_data[0] = 8'h11;
    hw_addr[1] = 3'd7; hw_data[1] = 8'h22;
    hw_req = 2'b11;
    step(g);
    check("rr_first", 32'(g), 0);
    hw_req[0] = 1'b0;
    check("hw0_addr", 32'(wr_addr), 6);
    step(g);
    check("rr_second", 32'(g), 1);
    hw_req[1] = 1'b0;
    check("hw1_data", 32'(wr_data), 32'h22);
    step(g);

    // SPI beats a held hw request on the same address.
    hw_req = 2'b01;
    spi(1'b1, 3'd6, 8'h33);
    step(g);
    idle();
    check("spi_first_data", 32'(wr_data), 32'h33);
    step(g);
    check("hw_after_spi", 32'(g), 0);
    hw_req = 2'b00;
    check("hw_after_data", 32'(wr_data), 32'h11);
    step(g);

    // Disabled: two strobes overflow the hold, newest survives.
    spi(1'b0, 3'd1, 8'h01);
    step(g);
    spi(1'b0, 3'd2, 8'h02);
    step(g);
    idle();
    step(g);
    check("ovf_set", 32'(spi_ovf), 1);
    ena = 1'b1;
    step(g);
    check("held_addr", 32'(wr_addr), 2);
    check("held_data", 32'(wr_data), 32'h02);
    step(g);
    ovf_clr = 1'b1;
    step(g);
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(spi_ovf), 0);
    step(g);

    // Set overflow again, then reset mid-write.
    spi(1'b0, 3'd1, 8'h55);
    step(g);
    spi(1'b0, 3'd4, 8'h66);
    step(g);
    spi(1'b1, 3'd3, 8'h44);
    step(g);
    idle();
    rstb = 1'b0;
    #1;
    check("mid_rst_wr_en", 32'(wr_en), 0);
    check("mid_rst_ovf", 32'(spi_ovf), 0);
    check("mid_rst_gnt", 32'(hw_gnt), 0);
    model_reset();
    @(posedge clk);
    #1;
    rstb = 1'b1;
    step(g);
    step(g);

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      ena         = ($urandom_range(0, 9) < 8);
      spi_wr_vld  = ($urandom_range(0, 9) < 3);
      spi_wr_addr = addr_t'($urandom);
      spi_wr_data = data_t'($urandom);
      ovf_clr     = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < N; i++) begin
        if (!hw_req[i] && $urandom_range(0, 9) < 4) begin
          hw_req[i]  = 1'b1;
          hw_addr[i] = ADDR_W_DEF'($urandom);
          hw_data[i] = DATA_W_DEF'($urandom);
        end
      end
      step(g);
      if (g >= 0) hw_req[g] = 1'b0;
    end
    idle();
    ena = 1'b1;
    hw_req = '0;
    step(g);
    step(g);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
